band_style_renderer: RTL
========================

Name: band_style_renderer

Overview:
- Pipelined per-pixel colour generator for the mobile LCD text overlay.
- Splits the screen vertically into NUM_BANDS bands of BAND_H rows each.
- Each band has a runtime-writable style: foreground colour, background colour, invert flag and blink flag.
- Sits between the font ROM/character lookup and the LCD pixel writer; the controller rewrites styles on bell, LED, RGB or lock events.

Parameters:
- NUM_BANDS, 15, number of styled bands; band i covers rows i*BAND_H .. i*BAND_H+BAND_H-1.
- BAND_H, 16, rows per band; must be a power of two.
- Y_W, 9, width of pixel_y.
- COLOR_W, 16, colour width (RGB565 at default).
- BLINK_FRAMES, 30, frames per blink half-period; must be ≥1.
- DEF_FG, 16'hffff, reset and out-of-range foreground colour.
- DEF_BG, 16'h0000, reset and out-of-range background colour.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pix_valid  in  1  input pixel qualifier
- font_bit  in  1  1 = glyph pixel (foreground)
- pixel_y  in  Y_W  pixel row
- frame_start  in  1  one-cycle pulse per frame
- style_we  in  1  style write strobe
- style_addr  in  clog2(NUM_BANDS)  band to write
- style_fg  in  COLOR_W  new foreground colour
- style_bg  in  COLOR_W  new background colour
- style_inv  in  1  new invert flag
- style_blink  in  1  new blink flag
- data  out  COLOR_W  pixel colour
- data_valid  out  1  data qualifier

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All band styles become fg=DEF_FG, bg=DEF_BG, inv=0, blink=0.
  - frame counter=0, blink_phase=0.
  - Pipeline valids=0; data=0; data_valid=0.
  - Reset mid-stream drops in-flight pixels; data_valid is 0 on the cycle after reset.
- Band index: band = pixel_y >> log2(BAND_H). If band ≥ NUM_BANDS, the pixel is out of range and uses DEF_FG/DEF_BG with no invert and no blink.
- Stage 1 (captured when pix_valid=1):
  - Style lookup on the current style registers.
  - Registers font_bit, selected fg/bg, swap = inv XOR (blink AND blink_phase), and valid.
  - Stage 1 loads every cycle; when pix_valid=0 its valid bit is 0.
- Stage 2:
  - data = (font_bit XOR swap) ? fg : bg.
  - data_valid = stage-1 valid.
  - Latency is exactly 2 cycles from pix_valid to data_valid.
  - Throughput is 1 pixel/cycle; there is no backpressure.
- When data_valid=0, data holds its last value.
- Style write:
  - On an edge where style_we=1 and style_addr < NUM_BANDS, all four fields of that band update together.
  - style_addr ≥ NUM_BANDS: the write is ignored.
  - A write and a pixel in the same band on the same edge: the pixel uses the pre-write style. The new style applies to pixels presented on the following cycle.
- Blink timer:
  - Each frame_start increments the frame counter.
  - When the counter would reach BLINK_FRAMES, it wraps to 0 and blink_phase toggles.
  - frame_start without pix_valid still counts.
  - A pixel presented on the same edge as a toggle uses the old phase.
- Invert and blink active together:
  - phase 0: inverted.
  - phase 1: normal (XOR rule).
- Sequential elements: style register file, frame counter, phase bit, two pipeline stages. No other state.

Test Plan:
- Reset, then pixel_y=0, font_bit=1, pix_valid=1 → two cycles later data=16'hffff, data_valid=1. Same with font_bit=0 → data=16'h0000.
- Write band 11 fg=16'h0000, bg=16'hf800, blink=0. Then pixel_y=176 (band 11), font_bit=0 → data=16'hf800. Pixel_y=175 (band 10) → data=16'h0000.
- Write band 13 bg=16'h07e0, inv=1. font_bit=1, pixel_y=210 → data=16'h07e0. font_bit=0 → data=fg.
- Blink with BLINK_FRAMES=2, band 0 blink=1, fg=16'hffff, bg=16'h0000, font_bit=0 on every cycle:
  - After 2 frame_start pulses → data=16'hffff.
  - After 4 pulses → data=16'h0000.
  - Pixel on the toggling edge still shows the old colour.
- Write band 2 on the same edge as a band-2 pixel → that pixel uses the old style, the next pixel the new one. Write with style_addr=15 → no band changes.
- pixel_y=250 (band 15, out of range), font_bit=1 → data=16'hffff. Assert rst_n=0 with pixels in flight → data_valid=0 the next cycle and data=0.

Source files
------------

// File: rtl/band_style_renderer.sv
// -----------------------------------------------------------------------------
// band_style_renderer
//
// Two-stage per-pixel colour generator for the LCD text overlay. The screen is
// cut vertically into NUM_BANDS bands of BAND_H rows. Each band has its own
// runtime-writable style: foreground, background, invert and blink. A
// frame-driven timer toggles a global blink phase every BLINK_FRAMES frames.
//
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   pix_valid, font_bit  incoming pixel qualifier and glyph bit (1 = fg)
//   pixel_y              row of the incoming pixel
//   frame_start          one-cycle pulse per frame (advances blink timer)
//   style_we/addr/fg/bg/inv/blink
//                        band style write port (out-of-range addr ignored)
//   data, data_valid     rendered colour, two cycles after pix_valid
// -----------------------------------------------------------------------------
module band_style_renderer #(
    parameter int                 NUM_BANDS    = 15,
    parameter int                 BAND_H       = 16,
    parameter int                 Y_W          = 9,
    parameter int                 COLOR_W      = 16,
    parameter int                 BLINK_FRAMES = 30,
    parameter logic [COLOR_W-1:0] DEF_FG       = 16'hffff,
    parameter logic [COLOR_W-1:0] DEF_BG       = 16'h0000,
    localparam int                A_W          = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    input  logic               font_bit,
    input  logic [Y_W-1:0]     pixel_y,
    input  logic               frame_start,
    input  logic               style_we,
    input  logic [A_W-1:0]     style_addr,
    input  logic [COLOR_W-1:0] style_fg,
    input  logic [COLOR_W-1:0] style_bg,
    input  logic               style_inv,
    input  logic               style_blink,
    output logic [COLOR_W-1:0] data,
    output logic               data_valid
);

    localparam int BAND_SH = $clog2(BAND_H);
    localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Style register file
    logic [COLOR_W-1:0] fg_q [NUM_BANDS];
    logic [COLOR_W-1:0] bg_q [NUM_BANDS];
    logic [NUM_BANDS-1:0] inv_q;
    logic [NUM_BANDS-1:0] blink_q;

    // Blink timer
    logic [CNT_W-1:0] frame_cnt_q;
    logic             blink_phase_q;

    // Stage 1
    logic               s1_valid_q;
    logic               s1_font_q;
    logic               s1_swap_q;
    logic [COLOR_W-1:0] s1_fg_q;
    logic [COLOR_W-1:0] s1_bg_q;
    logic               s1_swap_d;
    logic [COLOR_W-1:0] s1_fg_d;
    logic [COLOR_W-1:0] s1_bg_d;

    // Stage 2
    logic [COLOR_W-1:0] data_q;
    logic [COLOR_W-1:0] data_d;
    logic               data_valid_q;

    logic [Y_W-1:0] band;
    logic [A_W-1:0] band_idx;
    logic           band_in_range;
    logic           wr_in_range;

    assign band          = pixel_y >> BAND_SH;
    assign band_idx      = band[A_W-1:0];
    assign band_in_range = 32'(band) < 32'(NUM_BANDS);
    assign wr_in_range   = 32'(style_addr) < 32'(NUM_BANDS);

    // Lookup uses the registered styles/phase, so a same-edge write or phase
    // toggle only affects pixels presented on later cycles.
    always_comb begin
        s1_fg_d   = DEF_FG;
        s1_bg_d   = DEF_BG;
        s1_swap_d = 1'b0;
        if (band_in_range) begin
            s1_fg_d   = fg_q[band_idx];
            s1_bg_d   = bg_q[band_idx];
            s1_swap_d = inv_q[band_idx] ^ (blink_q[band_idx] & blink_phase_q);
        end
    end

    assign data_d = (s1_font_q ^ s1_swap_q) ? s1_fg_q : s1_bg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                fg_q[i] <= DEF_FG;
                bg_q[i] <= DEF_BG;
            end
            inv_q   <= '0;
            blink_q <= '0;
        end else if (style_we && wr_in_range) begin
            fg_q[style_addr]    <= style_fg;
            bg_q[style_addr]    <= style_bg;
            inv_q[style_addr]   <= style_inv;
            blink_q[style_addr] <= style_blink;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_font_q    <= 1'b0;
            s1_swap_q    <= 1'b0;
            s1_fg_q      <= '0;
            s1_bg_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            s1_valid_q   <= pix_valid;
            s1_font_q    <= font_bit;
            s1_swap_q    <= s1_swap_d;
            s1_fg_q      <= s1_fg_d;
            s1_bg_q      <= s1_bg_d;
            data_valid_q <= s1_valid_q;
            // Output colour is held between valid pixels.
            if (s1_valid_q) begin
                data_q <= data_d;
            end
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;

endmodule
